// File: rtl/smi_pkg.sv
// Shared constants, FSM state type and frame builder for the PHY management (Clause 22) bring-up logic.
package smi_pkg;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST       = 2'b01;

  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam int unsigned BMSR_LINK_BIT = 2;

  // Frame layout in bit cells: 32 preamble + ST/OP/PHYAD/REGAD, then TA and data.
  localparam int unsigned FRAME_CELLS    = 64;
  localparam int unsigned RD_DRIVE_CELLS = 46;
  localparam int unsigned DATA_CELL0     = 48;

  typedef enum logic [2:0] {
    S_RST_ASSERT,
    S_RST_WAIT,
    S_WR_BMCR,
    S_POLL_RD,
    S_POLL_CHK,
    S_POLL_WAIT,
    S_DONE
  } init_state_e;

  // Full 64-cell frame, MSB first. Read frames carry 1s in TA/data; the pad is released there anyway.
  function automatic logic [63:0] smi_frame(input logic        is_read,
                                            input logic [4:0]  phyad,
                                            input logic [4:0]  regad,
                                            input logic [15:0] wdata);
    if (is_read) begin
      return {32'hFFFF_FFFF, ST, OP_READ, phyad, regad, 2'b11, 16'hFFFF};
    end
    return {32'hFFFF_FFFF, ST, OP_WRITE, phyad, regad, 2'b10, wdata};
  endfunction

endpackage

// File: rtl/smi_phy_init_if.sv
// MDIO pad-side signal bundle: the bring-up block is the master, the PHY (or its model) the slave.
interface smi_phy_init_if;
  logic mdc_o;
  logic mdio_i;
  logic mdio_o;
  logic mdio_out_en;

  modport master (
    output mdc_o,
    output mdio_o,
    output mdio_out_en,
    input  mdio_i
  );

  modport slave (
    input  mdc_o,
    input  mdio_o,
    input  mdio_out_en,
    output mdio_i
  );
endinterface

// File: rtl/smi_phy_init_mdio_xfer.sv
// MDIO frame engine: shifts one 64-cell Clause 22 frame out (2 clocks per cell) and captures read data.
module mdio_xfer
  import smi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        is_read_i,
  input  logic [4:0]  phyad_i,
  input  logic [4:0]  regad_i,
  input  logic [15:0] wdata_i,
  input  logic        mdio_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_out_en_o
);

  logic        busy_q, busy_d;
  logic        phase_q, phase_d;     // 0 = cycle A (MDC low), 1 = cycle B (MDC high)
  logic [5:0]  cell_q, cell_d;
  logic        is_read_q, is_read_d;
  logic [63:0] shreg_q, shreg_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d;

  // Next-state: load on start, toggle phase, shift and capture at the end of each cycle B.
  always_comb begin
    busy_d    = busy_q;
    phase_d   = phase_q;
    cell_d    = cell_q;
    is_read_d = is_read_q;
    shreg_d   = shreg_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    if (!busy_q) begin
      if (start_i) begin
        busy_d    = 1'b1;
        phase_d   = 1'b0;
        cell_d    = '0;
        is_read_d = is_read_i;
        shreg_d   = smi_frame(is_read_i, phyad_i, regad_i, wdata_i);
      end
    end else if (!phase_q) begin
      phase_d = 1'b1;
    end else begin
      phase_d = 1'b0;
      shreg_d = {shreg_q[62:0], 1'b1};
      cell_d  = cell_q + 6'd1;
      if (is_read_q && (cell_q >= 6'(DATA_CELL0))) begin
        rdata_d = {rdata_q[14:0], mdio_i};
      end
      if (cell_q == 6'(FRAME_CELLS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= 1'b0;
      phase_q   <= 1'b0;
      cell_q    <= '0;
      is_read_q <= 1'b0;
      shreg_q   <= '1;
      rdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      phase_q   <= phase_d;
      cell_q    <= cell_d;
      is_read_q <= is_read_d;
      shreg_q   <= shreg_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
    end
  end

  // Pad outputs derive straight from registers so an async reset idles the bus at once.
  assign mdc_o         = busy_q & phase_q;
  assign mdio_o        = busy_q ? shreg_q[63] : 1'b1;
  assign mdio_out_en_o = busy_q & (~is_read_q | (cell_q < 6'(RD_DRIVE_CELLS)));
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign rdata_o       = rdata_q;

endmodule

// File: rtl/smi_phy_init.sv
// PHY bring-up sequencer: pulses phyrst, writes BMCR, polls BMSR until link up, then holds ready.
module smi_phy_init
  import smi_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR   = 5'h01,
  parameter logic [15:0] BMCR_VALUE = 16'h2100,
  parameter int unsigned RST_CYCLES = 10000,
  parameter int unsigned RST_WAIT   = 100000,
  parameter int unsigned POLL_GAP   = 1000
) (
  input  logic           clk1m,
  input  logic           rst,
  output logic           phyrst,
  output logic           ready,
  smi_phy_init_if.master mdio
);

  localparam int unsigned CNT_MAX =
    (RST_CYCLES > RST_WAIT) ? ((RST_CYCLES > POLL_GAP) ? RST_CYCLES : POLL_GAP)
                            : ((RST_WAIT   > POLL_GAP) ? RST_WAIT   : POLL_GAP);
  localparam int unsigned CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0] RST_TC  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_TC = CW'(RST_WAIT - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'(POLL_GAP - 1);

  init_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        xfer_start;
  logic        xfer_is_read;
  logic [4:0]  xfer_regad;
  logic        xfer_busy;
  logic        xfer_done;
  logic [15:0] bmsr;

  // Only the link bit of BMSR is consumed here.
  logic unused_bmsr_bits;
  assign unused_bmsr_bits = ^{bmsr[15:BMSR_LINK_BIT+1], bmsr[BMSR_LINK_BIT-1:0]};

  // Sequencer next-state. In the transfer states cnt_q doubles as an "already issued" flag.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    xfer_start   = 1'b0;
    xfer_is_read = 1'b0;
    xfer_regad   = REG_BMCR;
    case (state_q)
      S_RST_ASSERT: begin
        if (cnt_q == RST_TC) begin
          state_d = S_RST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == WAIT_TC) begin
          state_d = S_WR_BMCR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR_BMCR: begin
        xfer_regad = REG_BMCR;
        if (cnt_q == '0) begin
          if (!xfer_busy) begin
            xfer_start = 1'b1;
            cnt_d      = CW'(1);
          end
        end else if (xfer_done) begin
          state_d = S_POLL_RD;
          cnt_d   = '0;
        end
      end
      S_POLL_RD: begin
        xfer_is_read = 1'b1;
        xfer_regad   = REG_BMSR;
        if (cnt_q == '0) begin
          if (!xfer_busy) begin
            xfer_start = 1'b1;
            cnt_d      = CW'(1);
          end
        end else if (xfer_done) begin
          state_d = S_POLL_CHK;
          cnt_d   = '0;
        end
      end
      S_POLL_CHK: begin
        state_d = bmsr[BMSR_LINK_BIT] ? S_DONE : S_POLL_WAIT;
        cnt_d   = '0;
      end
      S_POLL_WAIT: begin
        if (cnt_q == GAP_TC) begin
          state_d = S_POLL_RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and delay counter.
  always_ff @(posedge clk1m or negedge rst) begin
    if (!rst) begin
      state_q <= S_RST_ASSERT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phyrst = (state_q != S_RST_ASSERT);
  assign ready  = (state_q == S_DONE);

  mdio_xfer u_xfer (
    .clk_i         (clk1m),
    .rst_ni        (rst),
    .start_i       (xfer_start),
    .is_read_i     (xfer_is_read),
    .phyad_i       (PHY_ADDR),
    .regad_i       (xfer_regad),
    .wdata_i       (BMCR_VALUE),
    .mdio_i        (mdio.mdio_i),
    .busy_o        (xfer_busy),
    .done_o        (xfer_done),
    .rdata_o       (bmsr),
    .mdc_o         (mdio.mdc_o),
    .mdio_o        (mdio.mdio_o),
    .mdio_out_en_o (mdio.mdio_out_en)
  );

endmodule

// File: tb/tb_smi_phy_init.sv
// Directed bench for smi_phy_init with a small Clause 22 PHY model decoding frames on MDC.
module tb_smi_phy_init;

  logic clk1m = 1'b0;
  logic rst;
  logic phyrst;
  logic ready;
  logic m_mdio = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  smi_phy_init_if bus();
  assign bus.mdio_i = m_mdio;

  smi_phy_init #(
    .PHY_ADDR   (5'h01),
    .BMCR_VALUE (16'h2100),
    .RST_CYCLES (10),
    .RST_WAIT   (20),
    .POLL_GAP   (8)
  ) dut (
    .clk1m  (clk1m),
    .rst    (rst),
    .phyrst (phyrst),
    .ready  (ready),
    .mdio   (bus)
  );

  always #5 clk1m = ~clk1m;
  always @(posedge clk1m) cyc <= cyc + 1;

  // PHY model state: frames decoded on MDC rising edges.
  logic [63:0] fr_bits  [32];
  int          fr_en    [32];
  int          fr_first [32];
  int          fr_last  [32];
  int          nfr      = 0;
  int          m_rises  = 0;
  int          m_cnt    = 0;
  int          m_en     = 0;
  int          m_rd_idx = 0;
  int          m_first  = 0;
  logic [63:0] m_sh     = '1;
  logic [1:0]  m_op     = 2'b00;
  logic [15:0] resp;

  initial forever begin
    @(posedge bus.mdc_o or negedge rst);
    if (rst !== 1'b1) begin
      m_cnt    = 0;
      m_en     = 0;
      m_rd_idx = 0;
      m_op     = 2'b00;
    end else begin
      m_rises++;
      if (m_cnt == 0) m_first = cyc;
      m_sh = {m_sh[62:0], bus.mdio_o};
      if (bus.mdio_out_en) m_en++;
      m_cnt++;
      if (m_cnt == 36) m_op = m_sh[1:0];
      if (m_cnt == 64) begin
        if (nfr < 32) begin
          fr_bits[nfr]  = m_sh;
          fr_en[nfr]    = m_en;
          fr_first[nfr] = m_first;
          fr_last[nfr]  = cyc;
        end
        nfr++;
        if (m_op == 2'b10) m_rd_idx++;
        m_cnt = 0;
        m_en  = 0;
      end
    end
  end

  // PHY drives read data after MDC falls; link comes up on the third poll after each reset.
  initial forever begin
    @(negedge bus.mdc_o);
    if (rst === 1'b1 && m_op == 2'b10 && m_cnt >= 48 && m_cnt <= 63) begin
      resp   = (m_rd_idx >= 2) ? 16'h780D : 16'h7809;
      m_mdio = resp[63 - m_cnt];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling clock edge: release rst and check phyrst rises on the 10th rising edge.
  task automatic release_and_check_phyrst();
    rst = 1'b1;
    repeat (9) @(posedge clk1m);
    #1 check_eq("phyrst_low_after_9", 32'(phyrst), 0);
    @(posedge clk1m);
    #1 check_eq("phyrst_high_after_10", 32'(phyrst), 1);
  endtask

  task automatic wait_frames(input int n, input int bound, input string tag);
    int i;
    i = 0;
    while (nfr < n && i < bound) begin
      @(negedge clk1m);
      i++;
    end
    check_eq(tag, 32'(nfr >= n), 1);
  endtask

  task automatic check_read_frame(input int idx);
    logic [63:0] fb;
    fb = fr_bits[idx];
    check_eq("rd_st",    32'(fb[31:30]), 32'h1);
    check_eq("rd_op",    32'(fb[29:28]), 32'h2);
    check_eq("rd_phyad", 32'(fb[27:23]), 32'h1);
    check_eq("rd_regad", 32'(fb[22:18]), 32'h1);
    check_eq("rd_en_cells", 32'(fr_en[idx]), 46);
  endtask

  initial begin
    logic [63:0] fb;
    logic        prev;
    int          ix;
    int          en_cycles;
    int          toggles;
    int          base;

    rst = 1'b0;
    repeat (5) @(posedge clk1m);
    @(negedge clk1m);
    check_eq("rst_phyrst", 32'(phyrst), 0);
    check_eq("rst_ready",  32'(ready), 0);
    check_eq("rst_en",     32'(bus.mdio_out_en), 0);
    check_eq("rst_mdc",    32'(bus.mdc_o), 0);
    check_eq("rst_mdio_o", 32'(bus.mdio_o), 1);

    release_and_check_phyrst();

    // Write frame: enable window and MDC toggle count.
    ix = 0;
    while (!bus.mdio_out_en && ix < 100) begin
      @(negedge clk1m);
      ix++;
    end
    check_eq("wr_frame_start", 32'(bus.mdio_out_en), 1);
    en_cycles = 0;
    toggles   = 0;
    prev      = 1'b0;
    while (bus.mdio_out_en && en_cycles < 300) begin
      if (bus.mdc_o !== prev) toggles++;
      prev = bus.mdc_o;
      en_cycles++;
      @(negedge clk1m);
    end
    if (bus.mdc_o !== prev) toggles++;
    check_eq("wr_en_cycles",  32'(en_cycles), 128);
    check_eq("wr_mdc_toggles", 32'(toggles), 128);

    wait_frames(1, 10, "wr_frame_logged");
    fb = fr_bits[0];
    check_eq("wr_preamble", fb[63:32], 32'hFFFF_FFFF);
    check_eq("wr_st",       32'(fb[31:30]), 32'h1);
    check_eq("wr_op",       32'(fb[29:28]), 32'h1);
    check_eq("wr_phyad",    32'(fb[27:23]), 32'h1);
    check_eq("wr_regad",    32'(fb[22:18]), 32'h0);
    check_eq("wr_ta",       32'(fb[17:16]), 32'h2);
    check_eq("wr_data",     32'(fb[15:0]),  32'h2100);
    check_eq("wr_en_cells", 32'(fr_en[0]), 64);

    // First poll: link down.
    wait_frames(2, 400, "rd1_seen");
    check_read_frame(1);
    check_eq("gap_wr_rd1_ge2", 32'((fr_first[1] - fr_last[0] - 2) >= 2), 1);
    repeat (6) @(negedge clk1m);
    check_eq("no_ready_poll1", 32'(ready), 0);

    // Second poll: still down, spaced by the poll gap.
    wait_frames(3, 400, "rd2_seen");
    check_read_frame(2);
    check_eq("gap_rd1_rd2_ge8", 32'((fr_first[2] - fr_last[1] - 2) >= 8), 1);
    repeat (6) @(negedge clk1m);
    check_eq("no_ready_poll2", 32'(ready), 0);

    // Third poll: link up.
    wait_frames(4, 400, "rd3_seen");
    ix = 0;
    while (!ready && ix < 10) begin
      @(negedge clk1m);
      ix++;
    end
    check_eq("ready_after_link_up", 32'(ready), 1);
    base = m_rises;
    repeat (300) @(negedge clk1m);
    check_eq("no_mdc_after_ready", 32'(m_rises - base), 0);
    check_eq("ready_sticky", 32'(ready), 1);
    check_eq("frames_after_ready", 32'(nfr), 4);

    // Restart, then hit rst during data bit 5 of the first read.
    rst = 1'b0;
    repeat (3) @(negedge clk1m);
    check_eq("rerst_ready", 32'(ready), 0);
    release_and_check_phyrst();
    ix = 0;
    while (!(m_op == 2'b10 && m_cnt == 53) && ix < 1000) begin
      @(negedge clk1m);
      ix++;
    end
    check_eq("mid_read_reached", 32'(m_op == 2'b10 && m_cnt == 53), 1);
    rst = 1'b0;
    #1;
    check_eq("mid_phyrst", 32'(phyrst), 0);
    check_eq("mid_ready",  32'(ready), 0);
    check_eq("mid_mdc",    32'(bus.mdc_o), 0);
    check_eq("mid_mdio_o", 32'(bus.mdio_o), 1);
    check_eq("mid_en",     32'(bus.mdio_out_en), 0);
    base = nfr;
    repeat (3) @(negedge clk1m);
    release_and_check_phyrst();
    ix = 0;
    while (!ready && ix < 2000) begin
      @(negedge clk1m);
      ix++;
    end
    check_eq("ready_after_restart", 32'(ready), 1);
    check_eq("frames_in_restart", 32'(nfr - base), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
